// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FULL    = 2'b01,
    SKIDDED = 2'b10
  } pipe_state_t;

  // Canonical bubble for instruction fields: sll $0,$0,0.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg_hs_if.sv
// Valid/ready handshake bundle for one pipeline stage, including flush and perf-counter controls.
interface pipe_reg_hs_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic              clr_cnt;

  // Environment side: drives both the upstream producer and downstream consumer ends.
  modport master (
    output in_valid, in_data, out_ready, flush, clr_cnt,
    input  in_ready, out_valid, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, clr_cnt,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipe_reg_hs.sv
// Handshaked pipeline-stage register with optional skid slot, flush-to-bubble and a stall counter.
module pipe_reg_hs
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       SKID        = 1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(NOP_INST),
  parameter int unsigned       CNT_W       = 16
) (
  input  logic          clock,
  input  logic          reset,
  pipe_reg_hs_if.slave  bus
);
  pipe_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_m, r_s, w_m_nxt, w_s_nxt;
  logic              w_out_valid, w_in_ready, w_accept, w_consume, w_stall;

  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_consume   = w_out_valid & bus.out_ready;

  // With the skid slot, in_ready depends only on registered state, breaking the out_ready path.
  generate
    if (SKID != 0) begin : g_skid
      assign w_in_ready = (r_state != SKIDDED);
    end else begin : g_noskid
      assign w_in_ready = ~w_out_valid | bus.out_ready;
    end
  endgenerate

  // NOTE: data registers are reset too, because out_data must read as the bubble straight after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_m     <= BUBBLE_DATA;
      r_s     <= BUBBLE_DATA;
    end else begin
      r_state <= w_state_nxt;
      r_m     <= w_m_nxt;
      r_s     <= w_s_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    if (bus.flush) begin
      w_state_nxt = EMPTY;
      w_m_nxt     = BUBBLE_DATA;
      w_s_nxt     = BUBBLE_DATA;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = FULL;
            w_m_nxt     = bus.in_data;
          end
        end
        FULL: begin
          if (w_accept && w_consume) begin
            w_m_nxt = bus.in_data;
          end else if (w_accept) begin
            w_state_nxt = SKIDDED;
            w_s_nxt     = bus.in_data;
          end else if (w_consume) begin
            w_state_nxt = EMPTY;
            w_m_nxt     = BUBBLE_DATA;
          end
        end
        SKIDDED: begin
          if (w_consume) begin
            w_state_nxt = FULL;
            w_m_nxt     = r_s;
            w_s_nxt     = BUBBLE_DATA;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_m_nxt     = BUBBLE_DATA;
          w_s_nxt     = BUBBLE_DATA;
        end
      endcase
    end
  end

  assign w_stall = w_out_valid & ~bus.out_ready & ~bus.flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_stall),
    .i_clr   (bus.clr_cnt),
    .o_count (bus.stall_cnt)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_m;
endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: a skid stage and a no-skid stage driven in parallel against a FIFO-occupancy model.
module tb_pipe_reg_hs;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 3;
  localparam logic [15:0] BUB_B = 16'hDEAD;
  localparam int          SAT   = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        t_in_valid  = 1'b0;
  logic [15:0] t_in_data   = '0;
  logic        t_out_ready = 1'b0;
  logic        t_flush     = 1'b0;
  logic        t_clr       = 1'b0;

  pipe_reg_hs_if #(.DATA_W(DW), .CNT_W(CW)) bus_a ();
  pipe_reg_hs_if #(.DATA_W(DW), .CNT_W(CW)) bus_b ();

  assign bus_a.in_valid  = t_in_valid;
  assign bus_a.in_data   = t_in_data;
  assign bus_a.out_ready = t_out_ready;
  assign bus_a.flush     = t_flush;
  assign bus_a.clr_cnt   = t_clr;
  assign bus_b.in_valid  = t_in_valid;
  assign bus_b.in_data   = t_in_data;
  assign bus_b.out_ready = t_out_ready;
  assign bus_b.flush     = t_flush;
  assign bus_b.clr_cnt   = t_clr;

  pipe_reg_hs #(.DATA_W(DW), .SKID(1), .BUBBLE_DATA(16'h0000), .CNT_W(CW)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  pipe_reg_hs #(.DATA_W(DW), .SKID(0), .BUBBLE_DATA(BUB_B), .CNT_W(CW)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid), plus a saturating integer.
  logic [15:0] m_q     [2][2];
  int          m_n     [2];
  int          m_stall [2];
  int          m_cap   [2] = '{2, 1};
  logic [15:0] m_bub   [2] = '{16'h0000, BUB_B};

  function automatic logic m_in_ready(input int k);
    if (m_cap[k] == 2) return (m_n[k] < 2);
    return (m_n[k] == 0) || t_out_ready;
  endfunction

  function automatic logic [15:0] m_out_data(input int k);
    return (m_n[k] > 0) ? m_q[k][0] : m_bub[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k]     = 0;
      m_stall[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic acc, cons;
      acc  = t_in_valid && m_in_ready(k);
      cons = (m_n[k] > 0) && t_out_ready;
      if (t_clr) m_stall[k] = 0;
      else if ((m_n[k] > 0) && !t_out_ready && !t_flush && (m_stall[k] < SAT)) m_stall[k]++;
      if (t_flush) begin
        m_n[k] = 0;
      end else begin
        if (cons) begin
          m_q[k][0] = m_q[k][1];
          m_n[k]--;
        end
        if (acc) begin
          m_q[k][m_n[k]] = t_in_data;
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic chk_inst(input int k, input string p, input logic ov, input logic [15:0] od,
                          input logic ir, input logic [2:0] sc);
    check({p, "_out_valid"}, ov, m_n[k] != 0);
    check({p, "_out_data"},  od, m_out_data(k));
    check({p, "_in_ready"},  ir, m_in_ready(k));
    check({p, "_stall_cnt"}, sc, m_stall[k]);
  endtask

  task automatic chk_all();
    chk_inst(0, "a", bus_a.out_valid, bus_a.out_data, bus_a.in_ready, bus_a.stall_cnt);
    chk_inst(1, "b", bus_b.out_valid, bus_b.out_data, bus_b.in_ready, bus_b.stall_cnt);
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f, input logic c);
    t_in_valid  = v;
    t_in_data   = d;
    t_out_ready = r;
    t_flush     = f;
    t_clr       = c;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    chk_all();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clock);
    #1;
    chk_all();
    reset = 1'b0;
    @(negedge clock);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      cycle();
      check("stream_a_data", bus_a.out_data, 64'(i));
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();

    // Skid: two payloads into a stalled stage, then drain in order.
    drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    cycle();
    check("skid_a_in_ready", bus_a.in_ready, 1'b0);
    check("skid_a_head", bus_a.out_data, 16'h000A);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("skid_a_second", bus_a.out_data, 16'h000B);
    cycle();
    check("skid_a_drained", bus_a.out_valid, 1'b0);

    // Flush from SKIDDED while offering a payload that must be dropped.
    drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h000C, 1'b0, 1'b1, 1'b0);
    cycle();
    check("flush_a_valid", bus_a.out_valid, 1'b0);
    check("flush_a_data", bus_a.out_data, 16'h0000);
    check("flush_a_ready", bus_a.in_ready, 1'b1);
    check("flush_b_data", bus_b.out_data, BUB_B);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Stall counter saturation and clear-during-stall.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle();
    check("stall_a_sat", bus_a.stall_cnt, 3'd7);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("stall_a_clr", bus_a.stall_cnt, 3'd0);

    // No-skid stage: in_ready follows out_ready combinationally while full.
    drive(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    #1;
    check("noskid_b_blocked", bus_b.in_ready, 1'b0);
    t_out_ready = 1'b1;
    #1;
    check("noskid_b_open", bus_b.in_ready, 1'b1);
    cycle();
    check("noskid_b_data", bus_b.out_data, 16'h0006);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
    cycle();

    // Randomised traffic with occasional flush and counter clear.
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
      cycle();
    end

    // Asynchronous reset in the middle of a cycle while SKIDDED.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    cycle();
    check("rst_pre_a_in_ready", bus_a.in_ready, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_a_valid", bus_a.out_valid, 1'b0);
    check("rst_a_data", bus_a.out_data, 16'h0000);
    check("rst_a_ready", bus_a.in_ready, 1'b1);
    check("rst_a_stall", bus_a.stall_cnt, 3'd0);
    chk_all();
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 16'h0007, 1'b1, 1'b0, 1'b0);
    cycle();
    check("post_rst_a_data", bus_a.out_data, 16'h0007);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
